// File: rtl/coreport_pkg.sv
// Shared constants and helpers for the GPIO input-conditioning stage.
package coreport_pkg;

    localparam int CP_DEFAULT_WIDTH = 8;

    localparam logic CP_MODE_LEVEL = 1'b0;
    localparam logic CP_MODE_EDGE  = 1'b1;
    localparam logic CP_POL_LOW    = 1'b0;
    localparam logic CP_POL_HIGH   = 1'b1;

    // Per-pin interrupt event for the selected mode/polarity.
    function automatic logic cp_event(
        input logic ier,
        input logic pol,
        input logic rise,
        input logic fall,
        input logic lvl
    );
        logic ev;
        if (ier == CP_MODE_EDGE)
            ev = (pol == CP_POL_HIGH) ? rise : fall;
        else
            ev = (pol == CP_POL_HIGH) ? lvl : ~lvl;
        return ev;
    endfunction

endpackage

// File: rtl/coreport_if.sv
// Pin/register bundle between the GPIO port block and its input conditioner.
interface coreport_if #(
    parameter int WIDTH      = 8,
    parameter int DEBOUNCE_W = 16
);

    logic [WIDTH-1:0]      pin_i;
    logic [DEBOUNCE_W-1:0] debounce_limit;
    logic [WIDTH-1:0]      ier_i;
    logic [WIDTH-1:0]      pol_i;
    logic [WIDTH-1:0]      imr_i;
    logic [WIDTH-1:0]      ifr_clr_i;
    logic [WIDTH-1:0]      data_o;
    logic [WIDTH-1:0]      rise_o;
    logic [WIDTH-1:0]      fall_o;
    logic [WIDTH-1:0]      ifr_o;
    logic                  irq;

    modport master (
        output pin_i, debounce_limit, ier_i, pol_i, imr_i, ifr_clr_i,
        input  data_o, rise_o, fall_o, ifr_o, irq
    );

    modport slave (
        input  pin_i, debounce_limit, ier_i, pol_i, imr_i, ifr_clr_i,
        output data_o, rise_o, fall_o, ifr_o, irq
    );

endinterface

// File: rtl/coreport_debounce.sv
// One pin: synchroniser chain, debounce counter and stable level.
module coreport_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pin,
    input  logic [DEBOUNCE_W-1:0] limit,
    output logic                  stable
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DEBOUNCE_W-1:0]  cnt;
    logic                   stable_q;
    logic                   sync_bit;

    assign sync_bit = sync_q[SYNC_STAGES-1];
    assign stable   = stable_q;

    always_ff @(posedge clk) begin
        if (rst)
            sync_q <= '0;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end

    // >= keeps the counter from wrapping if the limit drops mid-count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            stable_q <= 1'b0;
        end else if (sync_bit == stable_q) begin
            cnt <= '0;
        end else if (cnt >= limit) begin
            stable_q <= sync_bit;
            cnt      <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/coreport_edge.sv
// GPIO input conditioner: sync, debounce, edge detect, sticky maskable flags.
module coreport_edge
    import coreport_pkg::*;
#(
    parameter int WIDTH       = CP_DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 16
) (
    input  logic      wb_clk,
    input  logic      wb_rst,
    coreport_if.slave bus
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] ifr_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] event_v;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        coreport_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_W  (DEBOUNCE_W)
        ) u_db (
            .clk    (wb_clk),
            .rst    (wb_rst),
            .pin    (bus.pin_i[i]),
            .limit  (bus.debounce_limit),
            .stable (stable[i])
        );
    end

    assign rise = stable & ~prev_q;
    assign fall = ~stable & prev_q;

    always_comb begin
        event_v = '0;
        for (int i = 0; i < WIDTH; i++)
            event_v[i] = cp_event(bus.ier_i[i], bus.pol_i[i],
                                  rise[i], fall[i], stable[i]);
    end

    // Set wins over a same-cycle clear; level mode re-sets while active.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            prev_q <= '0;
            ifr_q  <= '0;
        end else begin
            prev_q <= stable;
            ifr_q  <= (ifr_q & ~bus.ifr_clr_i) | (event_v & bus.imr_i);
        end
    end

    assign bus.data_o = stable;
    assign bus.rise_o = rise;
    assign bus.fall_o = fall;
    assign bus.ifr_o  = ifr_q;
    assign bus.irq    = |(ifr_q & bus.imr_i);

endmodule

// File: tb/tb_coreport_edge.sv
// Directed scoreboard bench for coreport_edge.
module tb_coreport_edge;

    localparam int S_DATA = 0;
    localparam int S_RISE = 1;
    localparam int S_FALL = 2;
    localparam int S_IFR  = 3;
    localparam int S_IRQ  = 4;

    typedef struct {
        string      name;
        int         sig;
        logic [7:0] mask;
        logic [7:0] exp;
        int         cyc;
    } item_t;

    logic  clk = 1'b0;
    logic  wb_rst;
    int    cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    item_t sb[$];

    coreport_if #(.WIDTH(8), .DEBOUNCE_W(16)) bus ();

    coreport_edge #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .DEBOUNCE_W  (16)
    ) dut (
        .wb_clk (clk),
        .wb_rst (wb_rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] actual(int sig);
        logic [7:0] v;
        case (sig)
            S_DATA:  v = bus.data_o;
            S_RISE:  v = bus.rise_o;
            S_FALL:  v = bus.fall_o;
            S_IFR:   v = bus.ifr_o;
            default: v = {7'b0, bus.irq};
        endcase
        return v;
    endfunction

    // Monitor: compare every expectation due in this cycle.
    always @(negedge clk) begin
        item_t it;
        logic [7:0] a;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            it = sb.pop_front();
            a  = actual(it.sig) & it.mask;
            n_tests++;
            if (a !== (it.exp & it.mask)) begin
                n_fail++;
                $display("FAIL %s: got 0x%02h expected 0x%02h (cycle %0d)",
                         it.name, a, it.exp & it.mask, cyc);
            end
        end
    end

    task automatic chk(string nm, int sig, logic [7:0] m, logic [7:0] e);
        item_t it;
        it.name = nm;
        it.sig  = sig;
        it.mask = m;
        it.exp  = e;
        it.cyc  = cyc;
        sb.push_back(it);
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        wb_rst             = 1'b1;
        bus.pin_i          = 8'hFF;
        bus.debounce_limit = 16'd0;
        bus.ier_i          = 8'h00;
        bus.pol_i          = 8'h00;
        bus.imr_i          = 8'h00;
        bus.ifr_clr_i      = 8'h00;
        tick(3);

        // 1: reset state, pin high through reset propagates as a rise
        wb_rst = 1'b0;
        chk("t1_rst_data", S_DATA, 8'hFF, 8'h00);
        chk("t1_rst_rise", S_RISE, 8'hFF, 8'h00);
        chk("t1_rst_ifr", S_IFR, 8'hFF, 8'h00);
        chk("t1_rst_irq", S_IRQ, 8'h01, 8'h00);
        tick(2);
        chk("t1_data_2clk", S_DATA, 8'hFF, 8'h00);
        tick();
        n_tests++;
        if (bus.data_o !== 8'hFF) begin
            n_fail++;
            $display("FAIL d_t1_data: got 0x%02h", bus.data_o);
        end
        n_tests++;
        if (bus.rise_o !== 8'hFF) begin
            n_fail++;
            $display("FAIL d_t1_rise: got 0x%02h", bus.rise_o);
        end
        chk("t1_data_3clk", S_DATA, 8'hFF, 8'hFF);
        chk("t1_rise", S_RISE, 8'hFF, 8'hFF);
        chk("t1_fall", S_FALL, 8'hFF, 8'h00);
        tick();
        chk("t1_rise_end", S_RISE, 8'hFF, 8'h00);
        chk("t1_data_hold", S_DATA, 8'hFF, 8'hFF);

        // 2: glitch rejection and debounce latency with limit=4
        bus.pin_i = 8'h00;
        tick(4);
        chk("t2_settle", S_DATA, 8'hFF, 8'h00);
        bus.debounce_limit = 16'd4;
        bus.pin_i = 8'h01;
        tick(3);
        bus.pin_i = 8'h00;
        repeat (10) begin
            tick();
            chk("t2_glitch_data", S_DATA, 8'h01, 8'h00);
            chk("t2_glitch_rise", S_RISE, 8'h01, 8'h00);
        end
        bus.pin_i = 8'h01;
        repeat (6) begin
            tick();
            chk("t2_pending", S_DATA, 8'h01, 8'h00);
        end
        tick();
        n_tests++;
        if (bus.data_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL d_t2_data: got %b", bus.data_o[0]);
        end
        chk("t2_data_rise", S_DATA, 8'h01, 8'h01);
        chk("t2_rise", S_RISE, 8'h01, 8'h01);
        tick();
        chk("t2_rise_end", S_RISE, 8'h01, 8'h00);
        bus.debounce_limit = 16'd0;
        bus.pin_i = 8'h00;
        tick(4);
        chk("t2_low", S_DATA, 8'hFF, 8'h00);

        // 3: edge mode, rising polarity on pin0
        bus.ier_i = 8'h01;
        bus.pol_i = 8'h01;
        bus.imr_i = 8'h01;
        bus.pin_i = 8'h01;
        tick(3);
        chk("t3_rise", S_RISE, 8'h01, 8'h01);
        chk("t3_ifr_pre", S_IFR, 8'hFF, 8'h00);
        tick();
        chk("t3_ifr_set", S_IFR, 8'hFF, 8'h01);
        chk("t3_irq_set", S_IRQ, 8'h01, 8'h01);
        bus.ifr_clr_i = 8'h01;
        tick();
        bus.ifr_clr_i = 8'h00;
        chk("t3_ifr_clr", S_IFR, 8'hFF, 8'h00);
        chk("t3_irq_clr", S_IRQ, 8'h01, 8'h00);
        bus.pin_i = 8'h00;
        tick(3);
        chk("t3_fall", S_FALL, 8'h01, 8'h01);
        tick(2);
        chk("t3_fall_noflag", S_IFR, 8'hFF, 8'h00);

        // 4: level-low mode on pin1
        bus.ier_i = 8'h00;
        bus.pol_i = 8'h00;
        bus.imr_i = 8'h02;
        tick();
        chk("t4_ifr_lvl", S_IFR, 8'hFF, 8'h02);
        chk("t4_irq_lvl", S_IRQ, 8'h01, 8'h01);
        bus.ifr_clr_i = 8'h02;
        tick();
        bus.ifr_clr_i = 8'h00;
        chk("t4_clr_held", S_IFR, 8'h02, 8'h02);
        bus.pin_i = 8'h02;
        tick(3);
        chk("t4_pin1_high", S_DATA, 8'h02, 8'h02);
        tick();
        chk("t4_sticky", S_IFR, 8'h02, 8'h02);
        bus.ifr_clr_i = 8'h02;
        tick();
        bus.ifr_clr_i = 8'h00;
        chk("t4_clr_ok", S_IFR, 8'hFF, 8'h00);
        chk("t4_irq_off", S_IRQ, 8'h01, 8'h00);

        // 5: set beats clear on bit 2, then mask hides irq only
        bus.imr_i = 8'h04;
        tick();
        chk("t5_preset", S_IFR, 8'hFF, 8'h04);
        bus.ier_i = 8'h04;
        bus.pol_i = 8'h04;
        bus.pin_i = 8'h06;
        tick(3);
        chk("t5_rise", S_RISE, 8'h04, 8'h04);
        bus.ifr_clr_i = 8'h04;
        tick();
        bus.ifr_clr_i = 8'h00;
        chk("t5_set_wins", S_IFR, 8'hFF, 8'h04);
        bus.imr_i = 8'h00;
        chk("t5_irq_masked", S_IRQ, 8'h01, 8'h00);
        chk("t5_ifr_kept", S_IFR, 8'hFF, 8'h04);

        // 6: reset mid-debounce with flags pending
        bus.ier_i = 8'h00;
        bus.pol_i = 8'h00;
        bus.pin_i = 8'h55;
        tick(4);
        bus.ifr_clr_i = 8'hFF;
        tick();
        bus.ifr_clr_i = 8'h00;
        chk("t6_cleared", S_IFR, 8'hFF, 8'h00);
        bus.imr_i = 8'hFF;
        tick();
        chk("t6_ifr_aa", S_IFR, 8'hFF, 8'hAA);
        bus.imr_i = 8'h00;
        bus.debounce_limit = 16'd10;
        bus.pin_i = 8'h54;
        tick(5);
        bus.imr_i = 8'hFF;
        chk("t6_pre_data", S_DATA, 8'hFF, 8'h55);
        chk("t6_pre_irq", S_IRQ, 8'h01, 8'h01);
        wb_rst = 1'b1;
        tick();
        n_tests++;
        if (bus.ifr_o !== 8'h00) begin
            n_fail++;
            $display("FAIL d_t6_ifr: got 0x%02h", bus.ifr_o);
        end
        n_tests++;
        if (bus.irq !== 1'b0) begin
            n_fail++;
            $display("FAIL d_t6_irq: got %b", bus.irq);
        end
        chk("t6_rst_data", S_DATA, 8'hFF, 8'h00);
        chk("t6_rst_rise", S_RISE, 8'hFF, 8'h00);
        chk("t6_rst_fall", S_FALL, 8'hFF, 8'h00);
        chk("t6_rst_ifr", S_IFR, 8'hFF, 8'h00);
        chk("t6_rst_irq", S_IRQ, 8'h01, 8'h00);
        wb_rst = 1'b0;
        bus.imr_i = 8'h00;

        repeat (5) begin
            if (sb.size() > 0) tick();
        end
        while (sb.size() > 0) begin
            item_t it;
            it = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: never compared, expected 0x%02h", it.name, it.exp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
